// File: rtl/ars_subbytes_shiftrows.sv
// AES SubBytes+ShiftRows (or their inverses) over a 128-bit state, one 32-bit column per cycle
// through a single shared 4-byte S-box bank.
module ars_subbytes_shiftrows (
  input  logic         clk,
  input  logic         reset,
  input  logic         decrypt_i,
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [127:0] data_o
);

  typedef enum logic [2:0] {StIdle, StW0, StW1, StW2, StW3} state_e;

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic         mode_q, mode_d;
  logic [127:0] out_q, out_d;
  logic         ready_q, ready_d;

  logic [31:0]  word;
  logic [31:0]  sub_word;
  logic [127:0] sub_state;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // One inverter serves both directions; only the affine step moves around it.
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] pre;
    logic [7:0] y;
    pre = inv ? affine_inv(x) : x;
    y   = gf_inv(pre);
    return inv ? y : affine_fwd(y);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * src + r) -: 8];
      end
    end
    return o;
  endfunction

  always_comb begin
    word = data_q[127:96];
    unique case (state_q)
      StW1:    word = data_q[95:64];
      StW2:    word = data_q[63:32];
      StW3:    word = data_q[31:0];
      default: word = data_q[127:96];
    endcase
    sub_word = '0;
    for (int i = 0; i < 4; i++) begin
      sub_word[8 * i +: 8] = sbox(word[8 * i +: 8], mode_q);
    end
  end

  always_comb begin
    sub_state = data_q;
    unique case (state_q)
      StW0:    sub_state[127:96] = sub_word;
      StW1:    sub_state[95:64]  = sub_word;
      StW2:    sub_state[63:32]  = sub_word;
      StW3:    sub_state[31:0]   = sub_word;
      default: sub_state = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    out_d   = out_q;
    ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          data_d  = data_i;
          mode_d  = decrypt_i;
          state_d = StW0;
        end
      end
      StW0: begin
        data_d  = sub_state;
        state_d = StW1;
      end
      StW1: begin
        data_d  = sub_state;
        state_d = StW2;
      end
      StW2: begin
        data_d  = sub_state;
        state_d = StW3;
      end
      StW3: begin
        data_d  = sub_state;
        out_d   = shift_rows(sub_state, mode_q);
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign ready_o = ready_q;
  assign data_o  = out_q;

endmodule
